ls_sequencer: RTL and testbench

Multicycle load/store sequencer sitting between the control unit and the shared memory port of the multicycle MIPS datapath. It accepts one memory request at a time and drives the memory address, write-enable and write-data. It performs word, halfword and byte accesses on the 32-bit word memory, using read-modify-write for partial stores. The control unit starts a request, stalls on `busy`, and takes load data or an address error on the `done` pulse.

---
 rtl/ls_pkg.sv | 48 ++++
 rtl/lane_mux.sv | 70 +++++++
 rtl/ls_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ls_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ls_pkg
// Purpose : Shared definitions for the load/store sequencer: operation codes,
//           FSM state encoding and access-classification helpers.
// Contents: OP_* op encodings, state_t enum, is_aligned(), is_load()
// Revision: 1.0 - initial release
// ============================================================================
package ls_pkg;

  // Operation codes presented on the op port. Bit 2 distinguishes stores.
  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SB = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Returns 1 only for a legal op whose byte offset suits its access size.
  // Illegal op codes report as misaligned so a single test covers both
  // error causes.
  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LW, OP_SW: ok = (lo == 2'b00);
      OP_LH, OP_SH: ok = ~lo[0];
      OP_LB, OP_SB: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the three load codes; only meaningful for legal ops.
  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_mux.sv
`default_nettype none
// ============================================================================
// Module  : lane_mux
// Purpose : Byte-lane steering for little-endian word memory. Extracts and
//           sign-extends load data, and merges partial store data into a
//           word read from memory.
// Ports   : i_op     - operation code (ls_pkg OP_*)
//           i_lo     - byte offset within the word (addr[1:0])
//           i_word   - word read from memory
//           i_wdata  - store data (SH uses [15:0], SB uses [7:0])
//           o_load   - extracted, sign-extended load value
//           o_store  - full word to write back
// Revision: 1.0 - initial release
// ============================================================================
module lane_mux
  import ls_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];

    w_byte = i_word[7:0];
    case (i_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase

    o_load = i_word;
    case (i_op)
      OP_LH:   o_load = {{16{w_half[15]}}, w_half};
      OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      default: o_load = i_word;
    endcase

    // Start from the memory word and overwrite only the addressed lane(s).
    o_store = i_word;
    case (i_op)
      OP_SW: o_store = i_wdata;
      OP_SH: begin
        if (i_lo[1]) o_store[31:16] = i_wdata[15:0];
        else         o_store[15:0]  = i_wdata[15:0];
      end
      OP_SB: begin
        case (i_lo)
          2'd0:    o_store[7:0]   = i_wdata[7:0];
          2'd1:    o_store[15:8]  = i_wdata[7:0];
          2'd2:    o_store[23:16] = i_wdata[7:0];
          2'd3:    o_store[31:24] = i_wdata[7:0];
          default: o_store[7:0]   = i_wdata[7:0];
        endcase
      end
      default: o_store = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ls_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ls_sequencer
// Purpose : Multicycle load/store sequencer between the control unit and the
//           shared memory port. Handles one request at a time; word, half and
//           byte accesses, with read-modify-write for partial stores.
// Params  : MEM_LAT   - cycles from mem_addr valid to mem_rdata valid (>=1)
// Ports   : clk, reset (async, active-low)
//           start/op/addr/wdata  - request from control unit
//           busy/done/err/rdata  - status and load result to control unit
//           mem_addr/mem_w/mem_wdata/mem_rdata - memory port
// Revision: 1.0 - initial release
// ============================================================================
module ls_sequencer
  import ls_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_w,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [1:0]       r_lo;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_rdata;

  logic             w_accept;
  logic             w_ok;
  logic             w_capture;
  logic [31:0]      w_load;
  logic [31:0]      w_store;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_ok      = is_aligned(op, addr[1:0]);
  assign w_capture = (r_state == ST_RD) && (r_cnt == '0);

  // r_mem_wdata carries the raw store data until the read completes, at
  // which point it is replaced by the merged word; so it doubles as the
  // captured-word register for partial stores.
  lane_mux u_lane_mux (
    .i_op    (r_op),
    .i_lo    (r_lo),
    .i_word  (mem_rdata),
    .i_wdata (r_mem_wdata),
    .o_load  (w_load),
    .o_store (w_store)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs. Outputs come straight from the
  // state register so that an asynchronous reset drops mem_w immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    mem_w  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!w_ok)            w_next = ST_ERR;
          else if (op == OP_SW) w_next = ST_WR;
          else                  w_next = ST_RD;
        end
      end
      ST_RD: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_next = is_load(r_op) ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        busy   = 1'b1;
        mem_w  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        busy   = 1'b1;
        done   = 1'b1;
        err    = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latches, latency counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_op        <= OP_LW;
      r_lo        <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else if (w_accept && w_ok) begin
      // Error requests latch nothing: no memory access is made for them.
      r_cnt       <= CNT_LOAD;
      r_op        <= op;
      r_lo        <= addr[1:0];
      r_mem_addr  <= {addr[31:2], 2'b00};
      r_mem_wdata <= wdata;
    end else if (r_state == ST_RD) begin
      if (!w_capture) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (is_load(r_op)) begin
        r_rdata <= w_load;
      end else begin
        r_mem_wdata <= w_store;
      end
    end
  end

  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ls_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ls_sequencer
// Purpose : Directed self-checking bench for ls_sequencer (MEM_LAT=2) with a
//           small word memory model on the memory port.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ls_sequencer;
  import ls_pkg::*;

  localparam int MEM_LAT = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_w;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        tb_we  = 1'b0;
  logic [5:0]  tb_idx = '0;
  logic [31:0] tb_wd  = '0;

  int checks = 0;
  int errors = 0;
  int ndone;

  ls_sequencer #(.MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_w     (mem_w),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_w)      mem[mem_addr[7:2]] <= mem_wdata;
    else if (tb_we) mem[tb_idx]        <= tb_wd;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_poke(input logic [5:0] idx, input logic [31:0] d);
    tb_we  = 1'b1;
    tb_idx = idx;
    tb_wd  = d;
    tick();
    tb_we  = 1'b0;
  endtask

  // Issue one request in the current (idle) cycle and check every cycle up
  // to and including the first idle cycle after done.
  task automatic run_req(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input int done_cyc, input int wr_cyc,
                         input logic exp_err, input logic [31:0] exp_wd);
    start = 1'b1;
    op    = o;
    addr  = a;
    wdata = wd;
    tick();
    start = 1'b0;
    for (int c = 1; c <= done_cyc; c++) begin
      check1({tag, "_busy"}, busy, 1'b1);
      check1({tag, "_done"}, done, c == done_cyc);
      check1({tag, "_err"},  err,  exp_err && (c == done_cyc));
      check1({tag, "_memw"}, mem_w, c == wr_cyc);
      if (!exp_err) check32({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      if (c == wr_cyc) check32({tag, "_wdata"}, mem_wdata, exp_wd);
      tick();
    end
    check1({tag, "_idle_busy"}, busy, 1'b0);
    check1({tag, "_idle_done"}, done, 1'b0);
    check1({tag, "_idle_memw"}, mem_w, 1'b0);
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b0;
    tick();
    check1 ("rst_busy",   busy,      1'b0);
    check1 ("rst_done",   done,      1'b0);
    check1 ("rst_err",    err,       1'b0);
    check1 ("rst_memw",   mem_w,     1'b0);
    check32("rst_rdata",  rdata,     32'h0);
    check32("rst_maddr",  mem_addr,  32'h0);
    check32("rst_mwdata", mem_wdata, 32'h0);
    mem_poke(6'd4, 32'h8899AABB);
    mem_poke(6'd8, 32'h00000000);
    mem_poke(6'd9, 32'hA5A5A5A5);
    reset = 1'b1;
    tick();

    // Loads
    run_req("lw10", OP_LW, 32'h10, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lw10_rdata", rdata, 32'h8899AABB);
    run_req("lb13", OP_LB, 32'h13, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lb13_rdata", rdata, 32'hFFFFFF88);
    run_req("lh12", OP_LH, 32'h12, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lh12_rdata", rdata, 32'hFFFF8899);
    run_req("lh10", OP_LH, 32'h10, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lh10_rdata", rdata, 32'hFFFFAABB);
    run_req("lb11", OP_LB, 32'h11, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lb11_rdata", rdata, 32'hFFFFFFAA);
    run_req("lb10", OP_LB, 32'h10, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lb10_rdata", rdata, 32'hFFFFFFBB);

    // Partial stores (upper wdata bits must be ignored)
    run_req("sb11", OP_SB, 32'h11, 32'hFFFFFFCC, 4, 3, 1'b0, 32'h8899CCBB);
    check32("sb11_rdata", rdata, 32'hFFFFFFBB);
    check32("sb11_mem", mem[4], 32'h8899CCBB);
    mem_poke(6'd4, 32'h8899AABB);
    run_req("sh12", OP_SH, 32'h12, 32'hABCD1234, 4, 3, 1'b0, 32'h1234AABB);
    check32("sh12_mem", mem[4], 32'h1234AABB);
    run_req("lh12p", OP_LH, 32'h12, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lh12p_rdata", rdata, 32'h00001234);
    run_req("lb13p", OP_LB, 32'h13, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lb13p_rdata", rdata, 32'h00000012);

    // Full-word store
    run_req("sw20", OP_SW, 32'h20, 32'hDEADBEEF, 2, 1, 1'b0, 32'hDEADBEEF);
    check32("sw20_mem", mem[8], 32'hDEADBEEF);
    run_req("lw20", OP_LW, 32'h20, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lw20_rdata", rdata, 32'hDEADBEEF);

    // Errors: misaligned and illegal ops
    run_req("e_sh13", OP_SH,  32'h13, 32'h5555, 1, 0, 1'b1, 32'h0);
    run_req("e_op3",  3'b011, 32'h10, 32'h5555, 1, 0, 1'b1, 32'h0);
    run_req("e_lw12", OP_LW,  32'h12, 32'h0,    1, 0, 1'b1, 32'h0);
    run_req("e_op7",  3'b111, 32'h10, 32'h0,    1, 0, 1'b1, 32'h0);
    run_req("e_sw22", OP_SW,  32'h22, 32'h0,    1, 0, 1'b1, 32'h0);
    check32("err_rdata", rdata, 32'hDEADBEEF);
    check32("err_mem",   mem[4], 32'h1234AABB);

    // Start pulsed in cycles 1..3 of an LW yields a single done
    start = 1'b1; op = OP_LW; addr = 32'h10;
    tick();
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      start = (c <= 3);
      if (done) ndone++;
      tick();
    end
    start = 1'b0;
    check32("ign_ndone", ndone, 32'd1);
    check32("ign_rdata", rdata, 32'h1234AABB);
    check1 ("ign_busy",  busy,  1'b0);

    // Reset in cycle 1 of an SB
    start = 1'b1; op = OP_SB; addr = 32'h11; wdata = 32'h55;
    tick();
    start = 1'b0;
    check1("rsb_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    check1 ("rsb_busy",  busy,     1'b0);
    check1 ("rsb_memw",  mem_w,    1'b0);
    check32("rsb_maddr", mem_addr, 32'h0);
    check32("rsb_rdata", rdata,    32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check32("rsb_mem", mem[4], 32'h1234AABB);
    run_req("sb11b", OP_SB, 32'h11, 32'h55, 4, 3, 1'b0, 32'h123455BB);
    check32("sb11b_mem", mem[4], 32'h123455BB);
    run_req("lw10b", OP_LW, 32'h10, 32'h0, 3, 0, 1'b0, 32'h0);
    check32("lw10b_rdata", rdata, 32'h123455BB);

    // Reset during the write cycle of an SW drops mem_w before the edge
    start = 1'b1; op = OP_SW; addr = 32'h24; wdata = 32'h11111111;
    tick();
    start = 1'b0;
    check1("rsw_memw_pre", mem_w, 1'b1);
    reset = 1'b0;
    #1;
    check1("rsw_memw", mem_w, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check32("rsw_mem", mem[9], 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
